seq_div16by8: RTL and testbench

//   Sequential restoring divider: dividend / divisor -> quotient, remainder.

---
 rtl/seq_div16by8.sv | 143 ++++++++++++++
 tb/tb_seq_div16by8.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div16by8.sv
`default_nettype none
// ============================================================================
// Module   : seq_div16by8
// Brief    : Sequential restoring divider (dividend / divisor), one quotient
//            bit per clock, start/done handshake. Optional macro
//            DIV_OVF_CHECK_EN adds the q_ovf (quotient exceeds WD bits) flag.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div16by8 #(
    parameter int WN = 16,
    parameter int WD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [WN-1:0] dividend,
    input  logic [WD-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [WN-1:0] quotient,
    output logic [WD-1:0] remainder,
    output logic          div_zero
`ifdef DIV_OVF_CHECK_EN
    ,
    output logic          q_ovf
`endif
);

    localparam int              c_CW   = $clog2(WN);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_count;
    logic [WN-1:0]   r_q;
    logic [WD:0]     r_r;
    logic [WD-1:0]   r_divisor;
    logic [WN-1:0]   r_quotient;
    logic [WD-1:0]   r_remainder;
    logic            r_div_zero;
    logic            r_q_ovf;

    logic            w_accept;
    logic            w_last;
    logic [WD:0]     w_shift;
    logic [WD+1:0]   w_diff;
    logic            w_ge;
    logic [WD:0]     w_r_nxt;
    logic [WN-1:0]   w_q_nxt;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_RUN) && (r_count == c_LAST);

    // The borrow out of the extended subtraction decides the quotient bit.
    assign w_shift = {r_r[WD-1:0], r_q[WN-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_divisor};
    assign w_ge    = ~w_diff[WD+1];
    assign w_r_nxt = w_ge ? w_diff[WD:0] : w_shift;
    assign w_q_nxt = {r_q[WN-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_q_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_q       <= dividend;
            r_r       <= '0;
            r_count   <= '0;
            r_divisor <= divisor;
            if (divisor == '0) begin
                r_quotient  <= '1;
                r_remainder <= dividend[WD-1:0];
                r_div_zero  <= 1'b1;
                r_q_ovf     <= 1'b0;
            end else begin
                r_div_zero  <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_count <= r_count + c_CW'(1);
            if (w_last) begin
                r_quotient  <= w_q_nxt;
                r_remainder <= w_r_nxt[WD-1:0];
                r_q_ovf     <= |w_q_nxt[WN-1:WD];
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

`ifdef DIV_OVF_CHECK_EN
    assign q_ovf = r_q_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = r_q_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_div16by8.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_div16by8
// Brief    : Self-checking bench for seq_div16by8: arithmetic reference model,
//            per-cycle compare, directed cases and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_div16by8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
`ifdef DIV_OVF_CHECK_EN
    logic        q_ovf;
`endif

    seq_div16by8 #(.WN(16), .WD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
`ifdef DIV_OVF_CHECK_EN
        ,
        .q_ovf     (q_ovf)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an operation finishes 16 edges after acceptance
    // (immediately for a zero divisor); results come from plain arithmetic.
    int          e = 0;
    int          pend_edge = 0;
    int          done_edge = -10;
    bit          pend = 1'b0;
    logic [15:0] p_q, m_q = '0;
    logic [7:0]  p_r, m_r = '0;
    bit          p_ovf, m_ovf = 1'b0;
    bit          m_dz = 1'b0;
    bit          ok;

    always @(posedge clk) begin
        e = e + 1;
        if (!rst_n) begin
            pend = 1'b0; m_q = '0; m_r = '0; m_dz = 1'b0; m_ovf = 1'b0;
            done_edge = -10;
        end else begin
            ok = !pend;
            if (pend && e == pend_edge) begin
                m_q = p_q; m_r = p_r; m_ovf = p_ovf;
                pend = 1'b0;
                done_edge = e;
            end
            if (start && ok) begin
                if (divisor == 8'd0) begin
                    m_q = 16'hFFFF; m_r = dividend[7:0]; m_dz = 1'b1; m_ovf = 1'b0;
                    done_edge = e;
                end else begin
                    m_dz      = 1'b0;
                    pend      = 1'b1;
                    pend_edge = e + 16;
                    p_q       = dividend / {8'd0, divisor};
                    p_r       = 8'(dividend % {8'd0, divisor});
                    p_ovf     = ({8'd0, dividend[15:8]} >= {8'd0, divisor});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, pend);
            chk("done", done, (done_edge == e));
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_zero", div_zero, m_dz);
`ifdef DIV_OVF_CHECK_EN
            chk("q_ovf", q_ovf, m_ovf);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] dvd, input logic [7:0] dvs);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
            lat++;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int  lat;
        bit  any_done;

        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_zero, 0);
        rst_n = 1'b1;
        tick();

        launch(16'hFE01, 8'hFF);
        wait_done(lat);
        chk("t1_latency", lat, 16);
        chk("t1_q", quotient, 16'h00FF);
        chk("t1_r", remainder, 8'h00);
        chk("t1_dz", div_zero, 0);

        launch(16'd1000, 8'd7);
        wait_done(lat);
        chk("t2_q", quotient, 16'd142);
        chk("t2_r", remainder, 8'd6);
        launch(16'h0000, 8'h01);
        chk("t2_b2b_busy", busy, 1);
        wait_done(lat);
        chk("t2b_q", quotient, 16'h0000);
        chk("t2b_r", remainder, 8'h00);
        tick();

        launch(16'h1234, 8'h00);
        chk("t3_busy", busy, 0);
        wait_done(lat);
        chk("t3_latency", lat, 0);
        chk("t3_q", quotient, 16'hFFFF);
        chk("t3_r", remainder, 8'h34);
        chk("t3_dz", div_zero, 1);
        tick();

        launch(16'h0100, 8'h03);
        repeat (2) tick();
        dividend = 16'hABCD; divisor = 8'h07; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        dividend = 16'h5555; divisor = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        chk("t4_q", quotient, 16'h0055);
        chk("t4_r", remainder, 8'h01);
        chk("t4_dz", div_zero, 0);
        tick();

        launch(16'h1234, 8'h05);
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_q", quotient, 0);
        chk("t5_r", remainder, 0);
        any_done = 1'b0;
        repeat (20) begin
            tick();
            if (done) any_done = 1'b1;
        end
        chk("t5_no_done", any_done, 0);
        launch(16'h00FF, 8'h10);
        wait_done(lat);
        chk("t5b_q", quotient, 16'h000F);
        chk("t5b_r", remainder, 8'h0F);
        tick();

`ifdef DIV_OVF_CHECK_EN
        launch(16'hFF00, 8'h10);
        wait_done(lat);
        chk("t6_q", quotient, 16'h0FF0);
        chk("t6_r", remainder, 8'h00);
        chk("t6_ovf", q_ovf, 1);
        tick();
        launch(16'h0F00, 8'h10);
        wait_done(lat);
        chk("t6b_q", quotient, 16'h00F0);
        chk("t6b_ovf", q_ovf, 0);
        tick();
`endif

        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom % 4 == 0);
            dividend = 16'($urandom);
            if ($urandom % 10 == 0)     divisor = 8'h00;
            else if ($urandom % 3 == 0) divisor = 8'($urandom % 16);
            else                        divisor = 8'($urandom);
            rst_n    = ($urandom % 300 != 0);
            tick();
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
